axi_slave_mem: RTL and testbench

Parametrised AXI3 slave memory responder for the verification environment; it attaches to the slave side of the team's AXI interface (write, write-response and read channels with IDs and bursts) and stands in for a real target. It stores `DEPTH` words of `DATA_W` bits and supports FIXED, INCR and WRAP bursts of 1–16 beats with byte strobes. Address, write and read paths are independently sequenced, so one write burst and one read burst can be in flight at the same time.

---
 rtl/axi_slave_mem.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// axi_slave_mem
// AXI3 slave memory responder. Holds DEPTH words of DATA_W bits and answers
// FIXED, INCR and WRAP bursts of 1-16 beats with byte strobes. The write path
// (AW/W/B) and the read path (AR/R) run as two independent FSMs, so one write
// burst and one read burst can be in flight at the same time.
//
// Parameters: DATA_W (bus width, power of two >= 8), ADDR_W, ID_W,
//             DEPTH (words, power of two).
// Ports:
//   aclk, arst                               clock, async active-high reset
//   awid/awaddr/awlen/awsize/awburst         write address command
//   awvalid / awready                        write address handshake
//   wid/wdata/wstrb/wlast, wvalid / wready   write data beats
//   bid/bresp, bvalid / bready               write response
//   arid/araddr/arlen/arsize/arburst         read address command
//   arvalid / arready                        read address handshake
//   rid/rdata/rresp/rlast, rvalid / rready   read data beats
//
// Build option: AXI_MEM_SLVERR_EN
//   defined   - word indices >= DEPTH are errors (writes dropped, reads return
//               0 with SLVERR); bresp is SLVERR on any bad beat, wlast misplaced
//               or wid not matching the latched AWID.
//   undefined - word index wraps modulo DEPTH, wid/wlast ignored, always OKAY.
module axi_slave_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 256
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [3:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     wid,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [3:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
    typedef enum logic       {R_IDLE, R_DATA} rState_t;

    // Transfer sizes wider than the bus behave as full-width beats.
    function automatic logic [2:0] clampSize(input logic [2:0] size);
        return (size > 3'(LSB)) ? 3'(LSB) : size;
    endfunction

    // Address of the following beat. WRAP keeps the bits above the wrap
    // window and lets only the in-window offset roll over.
    function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] addr,
                                                   input logic [3:0] len,
                                                   input logic [2:0] size,
                                                   input logic [1:0] burst);
        logic [ADDR_W-1:0] incr;
        logic [ADDR_W-1:0] total;
        logic [ADDR_W-1:0] seq;
        incr  = ADDR_ONE << size;
        total = incr * ADDR_W'(len) + incr;
        seq   = addr + incr;
        if (burst == 2'b00) begin
            return addr;
        end else if (burst == 2'b10 &&
                     (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
            return (addr & ~(total - ADDR_ONE)) | (seq & (total - ADDR_ONE));
        end
        return seq;
    endfunction

    function automatic logic [IDX_W-1:0] wordIdx(input logic [ADDR_W-1:0] addr);
        return IDX_W'(addr >> LSB);
    endfunction

`ifdef AXI_MEM_SLVERR_EN
    function automatic logic outOfRange(input logic [ADDR_W-1:0] addr);
        return (addr >> (LSB + IDX_W)) != '0;
    endfunction
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    wState_t           wState_q;
    logic [ADDR_W-1:0] wAddr_q, wAddr_d;
    logic [3:0]        wLen_q, wBeat_q;
    logic [2:0]        wSize_q;
    logic [1:0]        wBurst_q;
    logic              wErr_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;

    rState_t           rState_q;
    logic [ADDR_W-1:0] rAddr_q, rAddr_d;
    logic [3:0]        rLen_q, rBeat_q;
    logic [2:0]        rSize_q;
    logic [1:0]        rBurst_q;
    logic              arready_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    logic              awHs, wHs, bHs, arHs, rHs;
    logic              wLastBeat, rLastBeat;
    logic [IDX_W-1:0]  wIdx, rLoadIdx;
    logic              wBeatErr, wBeatBad, memWe, rLoadErr;
    logic [DATA_W-1:0] rLoadData;

    assign awHs      = awvalid & awready_q;
    assign wHs       = wvalid & wready_q;
    assign bHs       = bvalid_q & bready;
    assign arHs      = arvalid & arready_q;
    assign rHs       = rvalid_q & rready;
    assign wLastBeat = (wBeat_q == wLen_q);
    assign rLastBeat = (rBeat_q == rLen_q);

    assign wAddr_d = nextAddr(wAddr_q, wLen_q, wSize_q, wBurst_q);
    assign wIdx    = wordIdx(wAddr_q);
    // The read path loads the word of the beat it will present next cycle:
    // the command address on AR, otherwise the advanced burst address.
    assign rAddr_d  = arHs ? araddr : nextAddr(rAddr_q, rLen_q, rSize_q, rBurst_q);
    assign rLoadIdx = wordIdx(rAddr_d);

`ifdef AXI_MEM_SLVERR_EN
    assign wBeatErr = outOfRange(wAddr_q);
    assign wBeatBad = wBeatErr | (wlast != wLastBeat) | (wid != bid_q);
    assign rLoadErr = outOfRange(rAddr_d);
`else
    logic unusedOk;
    assign unusedOk = &{1'b0, wid, wlast};
    assign wBeatErr = 1'b0;
    assign wBeatBad = 1'b0;
    assign rLoadErr = 1'b0;
`endif

    assign memWe = wHs & ~wBeatErr;

    // Word loaded into the read register. A write landing on the same word at
    // the same edge is merged in, so the next read of that word sees it while
    // the beat already on the bus keeps the old value.
    always_comb begin
        rLoadData = mem[rLoadIdx];
        if (memWe && (wIdx == rLoadIdx)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) rLoadData[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        if (rLoadErr) rLoadData = '0;
    end

    // Storage array, deliberately left out of reset so a partial burst
    // survives an abort.
    always_ff @(posedge aclk) begin
        if (memWe) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[wIdx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Write FSM. awready comes up in W_IDLE one cycle after reset release and
    // stays registered together with wready/bvalid.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            wState_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            wAddr_q   <= '0;
            wLen_q    <= '0;
            wSize_q   <= '0;
            wBurst_q  <= '0;
            wBeat_q   <= '0;
            wErr_q    <= 1'b0;
        end else begin
            case (wState_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awHs) begin
                        bid_q     <= awid;
                        wAddr_q   <= awaddr;
                        wLen_q    <= awlen;
                        wSize_q   <= clampSize(awsize);
                        wBurst_q  <= awburst;
                        wBeat_q   <= '0;
                        wErr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wState_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wHs) begin
                        wAddr_q <= wAddr_d;
                        wBeat_q <= wBeat_q + 4'd1;
                        wErr_q  <= wErr_q | wBeatBad;
                        if (wLastBeat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (wErr_q | wBeatBad) ? RESP_SLVERR : RESP_OKAY;
                            wState_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bHs) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        wState_q  <= W_IDLE;
                    end
                end
                default: wState_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM. Each beat's data, response and last flag are registered one
    // step ahead, so a stalled beat simply holds its registers.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            rState_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rAddr_q   <= '0;
            rLen_q    <= '0;
            rSize_q   <= '0;
            rBurst_q  <= '0;
            rBeat_q   <= '0;
        end else begin
            case (rState_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arHs) begin
                        rid_q     <= arid;
                        rAddr_q   <= araddr;
                        rLen_q    <= arlen;
                        rSize_q   <= clampSize(arsize);
                        rBurst_q  <= arburst;
                        rBeat_q   <= '0;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (arlen == 4'd0);
                        rdata_q   <= rLoadData;
                        rresp_q   <= rLoadErr ? RESP_SLVERR : RESP_OKAY;
                        rState_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rHs) begin
                        if (rLastBeat) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= RESP_OKAY;
                            arready_q <= 1'b1;
                            rState_q  <= R_IDLE;
                        end else begin
                            rAddr_q <= rAddr_d;
                            rBeat_q <= rBeat_q + 4'd1;
                            rlast_q <= ((rBeat_q + 4'd1) == rLen_q);
                            rdata_q <= rLoadData;
                            rresp_q <= rLoadErr ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: rState_q <= R_IDLE;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem
// Self-checking bench for axi_slave_mem. A word-array model of the memory is
// updated from the burst rules (beat address computed directly from the start
// address and beat number), and every R beat and B response is compared with
// it. Directed cases cover reset, single beats, INCR/WRAP bursts, strobes,
// out-of-range addresses and reset in the middle of a read; a randomized loop
// covers mixed burst types, sizes, lengths, strobes and back-pressure.
module tb_axi_slave_mem;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 256;
`ifdef AXI_MEM_SLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              aclk = 1'b0;
    logic              arst = 1'b1;
    logic [ID_W-1:0]   awid = '0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [3:0]        awlen = '0;
    logic [2:0]        awsize = '0;
    logic [1:0]        awburst = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [ID_W-1:0]   wid = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wlast = 1'b0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [ID_W-1:0]   arid = '0;
    logic [ADDR_W-1:0] araddr = '0;
    logic [3:0]        arlen = '0;
    logic [2:0]        arsize = '0;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready = 1'b0;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] modelMem [DEPTH];
    logic [31:0] beatData [16];
    logic [3:0]  beatStrb [16];

    axi_slave_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .arst(arst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge aclk);
        #1;
    endtask

    // Byte address of beat i of a burst, straight from the burst definitions.
    function automatic longint beatAddr(input longint start, input int len, input int size,
                                        input int burst, input int i);
        int     sz;
        longint incr;
        longint total;
        longint base;
        sz   = (size > 2) ? 2 : size;
        incr = longint'(1) << sz;
        if (burst == 0) return start;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            total = longint'(len + 1) * incr;
            base  = (start / total) * total;
            return base + ((start - base) + longint'(i) * incr) % total;
        end
        return start + longint'(i) * incr;
    endfunction

    function automatic bit isOor(input longint a);
        return (a >> 2) >= DEPTH;
    endfunction

    function automatic int wordOf(input longint a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic doWrite(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall);
        int          n;
        int          lenI;
        longint      a;
        logic [1:0]  expResp;
        lenI    = int'(len);
        expResp = 2'b00;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin waitCycle(); n++; end
        if (!awready) begin
            checkOutput("awreadyTimeout", 64'(awready), 64'(1));
            awvalid = 1'b0;
            return;
        end
        waitCycle();
        awvalid = 1'b0;
        checkOutput("wreadyAfterAw", 64'(wready), 64'(1));
        for (int i = 0; i <= lenI; i++) begin
            if (stall && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                waitCycle();
            end
            wvalid = 1'b1; wid = id; wdata = beatData[i]; wstrb = beatStrb[i];
            wlast = (i == lenI);
            n = 0;
            while (!wready && n < 100) begin waitCycle(); n++; end
            if (!wready) begin
                checkOutput("wreadyTimeout", 64'(wready), 64'(1));
                wvalid = 1'b0; wlast = 1'b0;
                return;
            end
            waitCycle();
            a = beatAddr(longint'(addr), lenI, int'(size), int'(burst), i);
            if (ERR_EN && isOor(a)) begin
                expResp = 2'b10;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (beatStrb[i][b]) modelMem[wordOf(a)][b*8 +: 8] = beatData[i][b*8 +: 8];
                end
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        checkOutput("bvalidAfterLast", 64'(bvalid), 64'(1));
        checkOutput("bid", 64'(bid), 64'(id));
        checkOutput("bresp", 64'(bresp), 64'(expResp));
        if (stall && $urandom_range(0, 1) == 1) begin
            waitCycle();
            checkOutput("bvalidHeld", 64'(bvalid), 64'(1));
            checkOutput("bidHeld", 64'(bid), 64'(id));
        end
        bready = 1'b1;
        waitCycle();
        bready = 1'b0;
        checkOutput("bvalidCleared", 64'(bvalid), 64'(0));
        checkOutput("awreadyAfterB", 64'(awready), 64'(1));
    endtask

    // stallMode 0: rready always high, 1: one idle cycle before every beat,
    // 2: random idle cycles.
    task automatic doRead(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stallMode);
        int          n;
        int          lenI;
        longint      a;
        logic [31:0] expData;
        logic [1:0]  expResp;
        bit          stall;
        lenI = int'(len);
        rready = 1'b0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin waitCycle(); n++; end
        if (!arready) begin
            checkOutput("arreadyTimeout", 64'(arready), 64'(1));
            arvalid = 1'b0;
            return;
        end
        waitCycle();
        arvalid = 1'b0;
        checkOutput("rvalidAfterAr", 64'(rvalid), 64'(1));
        for (int i = 0; i <= lenI; i++) begin
            a       = beatAddr(longint'(addr), lenI, int'(size), int'(burst), i);
            expData = (ERR_EN && isOor(a)) ? 32'h0 : modelMem[wordOf(a)];
            expResp = (ERR_EN && isOor(a)) ? 2'b10 : 2'b00;
            checkOutput("rvalid", 64'(rvalid), 64'(1));
            checkOutput("rdata", 64'(rdata), 64'(expData));
            checkOutput("rresp", 64'(rresp), 64'(expResp));
            checkOutput("rid", 64'(rid), 64'(id));
            checkOutput("rlast", 64'(rlast), 64'(i == lenI));
            stall = (stallMode == 1) || (stallMode == 2 && $urandom_range(0, 2) == 0);
            if (stall) begin
                rready = 1'b0;
                waitCycle();
                checkOutput("rdataHeld", 64'(rdata), 64'(expData));
                checkOutput("rlastHeld", 64'(rlast), 64'(i == lenI));
            end
            rready = 1'b1;
            waitCycle();
            rready = 1'b0;
        end
        checkOutput("rvalidCleared", 64'(rvalid), 64'(0));
        checkOutput("arreadyAfterLast", 64'(arready), 64'(1));
    endtask

    task automatic fillBeats(input int count, input bit randStrb);
        for (int i = 0; i < count; i++) begin
            beatData[i] = $urandom;
            beatStrb[i] = randStrb ? 4'($urandom) : 4'hF;
        end
    endtask

    // Randomized write/read pairs over mixed burst shapes and address ranges.
    task automatic applyStimulus(input int count);
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] addr;
        int          sz;
        for (int t = 0; t < count; t++) begin
            len   = 4'($urandom);
            size  = 3'($urandom_range(0, 3));
            burst = 2'($urandom);
            sz    = (int'(size) > 2) ? 2 : int'(size);
            addr  = 32'($urandom_range(0, 32'h8FF)) & ~((32'd1 << sz) - 32'd1);
            fillBeats(16, 1'b1);
            doWrite(4'($urandom), addr, len, size, burst, 1'b1);
            doRead(4'($urandom), addr, len, size, burst, 2);
            if ($urandom_range(0, 1) == 1) begin
                doRead(4'($urandom), 32'($urandom_range(0, 32'h3FF)) & ~32'd3,
                       4'($urandom), 3'd2, 2'd1, 2);
            end
        end
    endtask

    initial begin
        // Reset values.
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rstAwready", 64'(awready), 64'(0));
        checkOutput("rstArready", 64'(arready), 64'(0));
        checkOutput("rstWready", 64'(wready), 64'(0));
        checkOutput("rstBvalid", 64'(bvalid), 64'(0));
        checkOutput("rstRvalid", 64'(rvalid), 64'(0));
        checkOutput("rstRlast", 64'(rlast), 64'(0));
        checkOutput("rstBid", 64'(bid), 64'(0));
        checkOutput("rstRid", 64'(rid), 64'(0));
        checkOutput("rstBresp", 64'(bresp), 64'(0));
        checkOutput("rstRresp", 64'(rresp), 64'(0));
        checkOutput("rstRdata", 64'(rdata), 64'(0));
        arst = 1'b0;
        waitCycle();
        checkOutput("awreadyFirstEdge", 64'(awready), 64'(1));
        checkOutput("arreadyFirstEdge", 64'(arready), 64'(1));
        checkOutput("wreadyIdle", 64'(wready), 64'(0));

        // Give every word a known value.
        for (int blk = 0; blk < DEPTH / 16; blk++) begin
            fillBeats(16, 1'b0);
            doWrite(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 2'd1, 1'b0);
        end

        $display("[TB] single write/read");
        beatData[0] = 32'hDEADBEEF; beatStrb[0] = 4'hF;
        doWrite(4'd3, 32'h10, 4'd0, 3'd2, 2'd1, 1'b0);
        doRead(4'd3, 32'h10, 4'd0, 3'd2, 2'd1, 0);

        $display("[TB] INCR len 3 with stalled readback");
        for (int i = 0; i < 4; i++) begin beatData[i] = 32'(i + 1); beatStrb[i] = 4'hF; end
        doWrite(4'd1, 32'h40, 4'd3, 3'd2, 2'd1, 1'b0);
        doRead(4'd1, 32'h40, 4'd3, 3'd2, 2'd1, 1);

        $display("[TB] WRAP len 3 from 0x08");
        beatData[0] = 32'hA0A0A0A0; beatData[1] = 32'hB1B1B1B1;
        beatData[2] = 32'hC2C2C2C2; beatData[3] = 32'hD3D3D3D3;
        for (int i = 0; i < 4; i++) beatStrb[i] = 4'hF;
        doWrite(4'd2, 32'h08, 4'd3, 3'd2, 2'd2, 1'b0);
        doRead(4'd2, 32'h08, 4'd3, 3'd2, 2'd2, 0);
        doRead(4'd2, 32'h00, 4'd3, 3'd2, 2'd1, 0);

        $display("[TB] byte strobes");
        beatData[0] = 32'hFFFFFFFF; beatStrb[0] = 4'hF;
        doWrite(4'd4, 32'h20, 4'd0, 3'd2, 2'd1, 1'b0);
        beatData[0] = 32'h00000000; beatStrb[0] = 4'h5;
        doWrite(4'd4, 32'h20, 4'd0, 3'd2, 2'd1, 1'b0);
        doRead(4'd4, 32'h20, 4'd0, 3'd2, 2'd1, 0);

        $display("[TB] address beyond DEPTH");
        beatData[0] = 32'h13572468; beatStrb[0] = 4'hF;
        doWrite(4'd5, 32'h400, 4'd0, 3'd2, 2'd1, 1'b0);
        doRead(4'd5, 32'h400, 4'd0, 3'd2, 2'd1, 0);
        doRead(4'd5, 32'h000, 4'd0, 3'd2, 2'd1, 0);

        $display("[TB] randomized bursts");
        applyStimulus(40);

        $display("[TB] reset during a read burst");
        arid = 4'd6; araddr = 32'h40; arlen = 4'd3; arsize = 3'd2; arburst = 2'd1;
        arvalid = 1'b1;
        waitCycle();
        arvalid = 1'b0;
        rready = 1'b1;
        waitCycle();
        rready = 1'b0;
        checkOutput("midBeat2Data", 64'(rdata), 64'(modelMem[17]));
        arst = 1'b1;
        #1;
        checkOutput("abortRvalid", 64'(rvalid), 64'(0));
        checkOutput("abortRdata", 64'(rdata), 64'(0));
        checkOutput("abortArready", 64'(arready), 64'(0));
        waitCycle();
        arst = 1'b0;
        waitCycle();
        checkOutput("arreadyAfterAbort", 64'(arready), 64'(1));
        checkOutput("awreadyAfterAbort", 64'(awready), 64'(1));
        doRead(4'd6, 32'h40, 4'd3, 3'd2, 2'd1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
